conv_5_sdiv_24s_8s_16_seq: RTL and testbench
============================================

// Module: conv_5_sdiv_24s_8s_16_seq
// PURPOSE
// - Sequential signed divider: 24-bit signed dividend / 8-bit signed divisor -> 16-bit signed quotient + 8-bit signed remainder.
// - Inverse of the conv_5 16x8 DSP multiplier; rescales conv_5 accumulated products back to 16-bit feature values.
// - Radix-2 restoring division over magnitudes with valid/ready on both sides; one division in flight.
// PARAMETERS
// - ID          1   instance tag, no functional effect
// - din0_WIDTH  24  dividend width (signed)
// - din1_WIDTH  8   divisor width (signed)
// - dout_WIDTH  16  quotient width (signed, saturating)
// PORTS
// - ap_clk     in   1   clock, rising edge
// - ap_rst     in   1   reset, asynchronous, active-high
// - in_valid   in   1   din0/din1 valid
// - in_ready   out  1   block idle, can accept operands
// - din0       in   24  dividend, signed
// - din1       in   8   divisor, signed
// - out_valid  out  1   result valid, held until accepted
// - out_ready  in   1   consumer accepts result
// - quot       out  16  quotient, truncated toward zero, saturated
// - rem        out  8   remainder, sign of dividend, |rem| < |din1|
// - ovf        out  1   quotient saturated (magnitude out of range)
// - dz         out  1   divide by zero
// BEHAVIOUR
// - Reset: state IDLE; out_valid=0, quot=0, rem=0, ovf=0, dz=0; in_ready=0 while ap_rst=1, 1 after release.
// - States: IDLE -> CALC -> FIX -> DONE -> IDLE.
// - IDLE: in_ready=1. On in_valid&in_ready: latch |din0| (24b unsigned), |din1| (8b unsigned; -128 -> 128), both signs, dz=(din1==0); cnt=23; go CALC.
// - CALC: one restoring step per cycle: shift next dividend MSB into a 9-bit partial remainder, subtract |divisor|, keep on non-negative, shift quotient bit in. Decrement cnt; after step with cnt==0 go FIX (24 cycles).
// - FIX: apply signs: quotient negated if signs differ, remainder negated if dividend negative. Register quot/rem/ovf/dz, go DONE.
// - DONE: out_valid=1; outputs stable until out_valid&out_ready; then IDLE next cycle (in_ready=0 in that cycle).
// - Latency fixed: out_valid rises 26 cycles after the accepting edge, also for dz; throughput one op per >=27 cycles.
// - Saturation: signed 25-bit quotient > 32767 -> quot=32767, ovf=1; < -32768 -> quot=-32768, ovf=1. Exact -32768 is not ovf.
// - dz=1: quot=32767 if din0>=0 else -32768; rem=din0[7:0]; ovf=0. Datapath runs its normal cycles, results discarded.
// - Operands sampled only at acceptance; din0/din1 changes later are ignored.
// - in_valid while busy is ignored (no queueing); upstream must hold until in_ready.
// - ap_rst mid-operation: in-flight division dropped, no output produced, all outputs return to reset values immediately.
// - Width rules: partial remainder 9 bits unsigned; magnitude quotient 24 bits; -8388608 magnitude = 8388608 fits 24b unsigned.
// STRUCTURE
// - Package conv_5_div_pkg: state enum (IDLE,CALC,FIX,DONE), DIV_STEPS=24, DIV_LATENCY=26, Q_MAX=16'sh7FFF, Q_MIN=16'sh8000.
// - One sub-module conv_5_udiv_step: combinational restoring step (9b rem, 24b dividend shift, 8b divisor -> next rem, quotient bit).
// - Top holds FSM, counter, sign/abs logic, saturation and output registers.
// TESTING
// - 1000 / 7 -> quot=142, rem=6, ovf=0, dz=0; out_valid exactly 26 cycles after accept.
// - -1000 / 7 -> quot=-142, rem=-6; 1000 / -128 -> quot=-7, rem=104.
// - 8388607 / 1 -> quot=32767, ovf=1; -8388608 / -1 -> quot=32767, ovf=1; -32768 / 1 -> quot=-32768, ovf=0.
// - 500 / 0 -> dz=1, quot=32767, rem=8'hF4; -500 / 0 -> dz=1, quot=-32768.
// - Backpressure: out_ready=0 for 10 cycles -> outputs stable, in_ready=0, second in_valid ignored; accept -> IDLE next cycle.
// - Assert ap_rst at cycle 12 of CALC -> out_valid=0 at once, no result emitted; after release new op 100/3 -> quot=33, rem=1.

Source files
------------

// File: rtl/conv_5_div_pkg.sv
// Shared types and constants for the conv_5 signed sequential divider.
// Rescales 24-bit conv_5 accumulator values back to 16-bit feature values.
package conv_5_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DIV_STEPS   = 24;
   localparam int DIV_LATENCY = 26;

   localparam logic signed [15:0] Q_MAX = 16'sh7FFF;
   localparam logic signed [15:0] Q_MIN = 16'sh8000;

endpackage

// File: rtl/conv_5_udiv_step.sv
// One radix-2 restoring division step on magnitudes: shift the next dividend
// bit into the partial remainder and subtract the divisor when it fits.
module conv_5_udiv_step (
   input  logic [8:0]  rem_in,
   input  logic [23:0] dvd_in,
   input  logic [7:0]  dvs,
   output logic [8:0]  rem_out,
   output logic [23:0] dvd_out,
   output logic        q_bit
);

   logic [9:0] shifted;
   logic [9:0] diff;

   always_comb begin
      shifted = {rem_in, dvd_in[23]};
      diff    = shifted - {2'b00, dvs};
      q_bit   = (shifted >= {2'b00, dvs});
      rem_out = q_bit ? 9'(diff) : 9'(shifted);
      dvd_out = {dvd_in[22:0], 1'b0};
   end

endmodule

// File: rtl/conv_5_sdiv_24s_8s_16_seq.sv
// Sequential signed divider: 24b dividend / 8b divisor -> saturated 16b
// quotient and 8b remainder, valid/ready on both sides, one op in flight.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// CALC  | one restoring step per cycle on magnitudes (24 cycles)
// FIX   | apply signs, saturate, handle divide-by-zero, register results
// DONE  | result presented (out_valid one cycle after entry), held until taken
module conv_5_sdiv_24s_8s_16_seq
   import conv_5_div_pkg::*;
#(
   parameter int ID         = 1,
   parameter int din0_WIDTH = 24,
   parameter int din1_WIDTH = 8,
   parameter int dout_WIDTH = 16
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] quot,
   output logic [7:0]            rem,
   output logic                  ovf,
   output logic                  dz
);

   // Instance tag only; no hardware depends on it.
   if (ID < 0) begin : g_id_tag
   end

   state_t state, state_nxt;

   logic [4:0]  cnt;
   logic [23:0] dvd;
   logic [7:0]  dvs;
   logic [8:0]  prem;
   logic [23:0] qmag;
   logic        neg_n, neg_d, dz_r;
   logic [7:0]  low_byte;

   logic [8:0]  step_rem;
   logic [23:0] step_dvd;
   logic        step_q;

   logic signed [24:0] qpos, q25;
   logic signed [15:0] quot_fix;
   logic [7:0]         rem_fix;
   logic               ovf_fix;

   conv_5_udiv_step u_step (
      .rem_in  (prem),
      .dvd_in  (dvd),
      .dvs     (dvs),
      .rem_out (step_rem),
      .dvd_out (step_dvd),
      .q_bit   (step_q)
   );

   assign in_ready = (state == IDLE) && !ap_rst;

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)               state_nxt = CALC;
         CALC:    if (cnt == 5'd0)            state_nxt = FIX;
         FIX:                                 state_nxt = DONE;
         DONE:    if (out_valid && out_ready) state_nxt = IDLE;
         default:                             state_nxt = IDLE;
      endcase
   end

   // Sign application and saturation; divide-by-zero overrides the datapath.
   always_comb begin
      qpos     = {1'b0, qmag};
      q25      = (neg_n ^ neg_d) ? -qpos : qpos;
      quot_fix = q25[15:0];
      rem_fix  = neg_n ? 8'(-prem) : 8'(prem);
      ovf_fix  = 1'b0;
      if (dz_r) begin
         quot_fix = neg_n ? Q_MIN : Q_MAX;
         rem_fix  = low_byte;
      end else if (q25 > 25'sd32767) begin
         quot_fix = Q_MAX;
         ovf_fix  = 1'b1;
      end else if (q25 < -25'sd32768) begin
         quot_fix = Q_MIN;
         ovf_fix  = 1'b1;
      end
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         cnt       <= '0;
         dvd       <= '0;
         dvs       <= '0;
         prem      <= '0;
         qmag      <= '0;
         neg_n     <= 1'b0;
         neg_d     <= 1'b0;
         dz_r      <= 1'b0;
         low_byte  <= '0;
         quot      <= '0;
         rem       <= '0;
         ovf       <= 1'b0;
         dz        <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state == DONE) && !(out_valid && out_ready);
         case (state)
            IDLE: if (in_valid) begin
               dvd      <= din0[23] ? 24'(-din0) : din0;
               dvs      <= din1[7]  ? 8'(-din1)  : din1;
               neg_n    <= din0[23];
               neg_d    <= din1[7];
               dz_r     <= (din1 == '0);
               low_byte <= din0[7:0];
               prem     <= '0;
               qmag     <= '0;
               cnt      <= 5'(DIV_STEPS - 1);
            end
            CALC: begin
               prem <= step_rem;
               dvd  <= step_dvd;
               qmag <= {qmag[22:0], step_q};
               cnt  <= cnt - 5'd1;
            end
            FIX: begin
               quot <= quot_fix;
               rem  <= rem_fix;
               ovf  <= ovf_fix;
               dz   <= dz_r;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_5_sdiv_24s_8s_16_seq.sv
// Scoreboard bench for the conv_5 signed divider: directed corner cases,
// backpressure, mid-operation reset and randomized operands vs. an arithmetic model.
module tb_conv_5_sdiv_24s_8s_16_seq;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] din0;
   logic [7:0]  din1;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quot;
   logic [7:0]  rem;
   logic        ovf;
   logic        dz;

   always #5 ap_clk = ~ap_clk;

   conv_5_sdiv_24s_8s_16_seq #(
      .ID(1), .din0_WIDTH(24), .din1_WIDTH(8), .dout_WIDTH(16)
   ) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .din0(din0), .din1(din1),
      .out_valid(out_valid), .out_ready(out_ready),
      .quot(quot), .rem(rem), .ovf(ovf), .dz(dz)
   );

   typedef struct {
      logic signed [15:0] q;
      logic signed [7:0]  r;
      logic               ovf;
      logic               dz;
      longint             acc;
   } exp_t;

   exp_t   exp_q[$];
   int     n_chk  = 0;
   int     n_fail = 0;
   longint cyc    = 0;
   bit     rnd_rdy = 0;
   logic   prev_ov = 1'b0;

   always @(posedge ap_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer division truncates toward zero and % takes
   // the dividend's sign, which is exactly the required result.
   function automatic exp_t model(input longint a, input longint b);
      exp_t   e;
      longint q, r;
      logic [63:0] abits;
      e.acc = 0;
      e.ovf = 1'b0;
      e.dz  = 1'b0;
      if (b == 0) begin
         abits = a;
         e.dz  = 1'b1;
         e.q   = (a >= 0) ? 16'sh7FFF : 16'sh8000;
         e.r   = abits[7:0];
      end else begin
         q = a / b;
         r = a % b;
         if (q > 32767) begin
            q = 32767;
            e.ovf = 1'b1;
         end else if (q < -32768) begin
            q = -32768;
            e.ovf = 1'b1;
         end
         e.q = 16'(q);
         e.r = 8'(r);
      end
      return e;
   endfunction

   // Monitor: compares whatever the DUT presents against the queue head.
   always @(negedge ap_clk) begin
      exp_t e;
      if (out_valid) begin
         chk("in_ready_while_out_valid", longint'(in_ready), 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            e = exp_q[0];
            if (!prev_ov) chk("latency", cyc - e.acc, 26);
            chk("quot", longint'($signed(quot)), longint'(e.q));
            chk("rem",  longint'($signed(rem)),  longint'(e.r));
            chk("ovf",  longint'(ovf), longint'(e.ovf));
            chk("dz",   longint'(dz),  longint'(e.dz));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
      prev_ov = out_valid;
   end

   task automatic issue(input logic signed [23:0] a, input logic signed [7:0] b,
                        input bit push);
      exp_t e;
      bit   done = 0;
      @(negedge ap_clk);
      din0     = a;
      din1     = b;
      in_valid = 1'b1;
      for (int g = 0; g < 2000 && !done; g++) begin
         if (in_ready) begin
            if (push) begin
               e = model(longint'(a), longint'(b));
               e.acc = cyc + 1;
               exp_q.push_back(e);
            end
            done = 1;
         end else begin
            @(posedge ap_clk);
            #1;
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge ap_clk);
         end
      end
      if (!done) chk("accept_timeout", 0, 1);
      @(posedge ap_clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && g < 200) begin
         @(posedge ap_clk);
         #1;
         g++;
      end
      chk("drain_timeout", longint'(exp_q.size()), 0);
   endtask

   localparam int ND = 9;
   int da [ND] = '{1000, -1000, 1000, 8388607, -8388608, -32768, 500, -500, 0};
   int db [ND] = '{7,    7,     -128, 1,       -1,       1,      0,   0,    5};

   initial begin
      logic signed [23:0] ra;
      logic signed [7:0]  rb;
      int g;

      ap_rst = 1'b1; in_valid = 1'b0; din0 = '0; din1 = '0; out_ready = 1'b1;
      #12;
      chk("rst_in_ready",  longint'(in_ready), 0);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_quot",      longint'(quot), 0);
      chk("rst_rem",       longint'(rem), 0);
      chk("rst_ovf",       longint'(ovf), 0);
      chk("rst_dz",        longint'(dz), 0);
      @(negedge ap_clk);
      ap_rst = 1'b0;
      #1;
      chk("post_rst_in_ready", longint'(in_ready), 1);

      for (int i = 0; i < ND; i++) issue(24'(da[i]), 8'(db[i]), 1'b1);
      drain();

      // Backpressure: hold result, extra in_valid must be ignored.
      out_ready = 1'b0;
      issue(24'sd1000, 8'sd7, 1'b1);
      g = 0;
      while (!out_valid && g < 100) begin @(posedge ap_clk); #1; g++; end
      chk("bp_out_valid_seen", longint'(out_valid), 1);
      din0 = 24'd5; din1 = 8'd1; in_valid = 1'b1;
      repeat (10) begin
         @(negedge ap_clk);
         chk("bp_in_ready_low", longint'(in_ready), 0);
      end
      @(posedge ap_clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge ap_clk);
      @(negedge ap_clk);
      chk("bp_out_valid_drop", longint'(out_valid), 0);
      chk("bp_idle_next",      longint'(in_ready), 1);

      // Reset in the middle of CALC drops the operation.
      issue(24'sd1000, 8'sd7, 1'b0);
      repeat (11) @(posedge ap_clk);
      #3;
      ap_rst = 1'b1;
      #1;
      chk("midrst_out_valid", longint'(out_valid), 0);
      chk("midrst_in_ready",  longint'(in_ready), 0);
      chk("midrst_quot",      longint'(quot), 0);
      chk("midrst_rem",       longint'(rem), 0);
      repeat (2) @(negedge ap_clk);
      ap_rst = 1'b0;
      issue(24'sd100, 8'sd3, 1'b1);
      drain();

      // Randomized operands with random output backpressure.
      rnd_rdy = 1;
      for (int i = 0; i < 40; i++) begin
         ra = 24'($urandom);
         if ($urandom_range(0, 1) == 1) ra = ra >>> $urandom_range(4, 20);
         rb = 8'($urandom);
         if ($urandom_range(0, 9) == 0) rb = '0;
         issue(ra, rb, 1'b1);
      end
      rnd_rdy = 0;
      drain();
      repeat (40) @(posedge ap_clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
